maxpool_stream: RTL

Parametrised streaming K×K max-pooling stage for the CNN datapath. It accepts a raster-ordered pixel stream of an IMG_W×IMG_H feature map over a valid/ready handshake. It reduces each non-overlapping K×K window to its maximum and emits the pooled map, also raster-ordered, with a frame-end marker. It sits between the convolution output stage and the next layer and replaces the fixed 4-bit, 7×7, self-contained pooling block with a back-pressured, size-generic stage.

---
 rtl/maxpool_stream.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming KxK max-pooling stage with valid/ready on both sides, raster order in and out.
// Build option MAXPOOL_SIGNED_EN: compare pixels as two's-complement signed (default unsigned).
`default_nettype none

module maxpool_stream #(
  parameter int DATA_W = 4,
  parameter int IMG_W  = 7,
  parameter int IMG_H  = 7,
  parameter int K      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int OUT_W = IMG_W / K;
  localparam int OUT_H = IMG_H / K;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int KW    = $clog2(K);
  localparam int WCW   = $clog2(OUT_W + 1);
  localparam int WRW   = $clog2(OUT_H + 1);
  localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [CW-1:0]  COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_MAX = RW'(IMG_H - 1);
  localparam logic [KW-1:0]  K_MAX   = KW'(K - 1);
  localparam logic [WCW-1:0] WC_LIM  = WCW'(OUT_W);
  localparam logic [WRW-1:0] WR_LIM  = WRW'(OUT_H);
  localparam logic [WCW-1:0] WC_LAST = WCW'(OUT_W - 1);
  localparam logic [WRW-1:0] WR_LAST = WRW'(OUT_H - 1);

  // Raster position plus its window decomposition (kc = col%K, wc = col/K, likewise for rows).
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [KW-1:0]     kc;
  logic [KW-1:0]     kr;
  logic [WCW-1:0]    wc;
  logic [WRW-1:0]    wr;
  logic [DATA_W-1:0] acc [OUT_W];

  logic              accept;
  logic              in_range;
  logic              win_first;
  logic              win_done;
  logic              frame_last;
  logic              pix_gt;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] acc_sel;
  logic [DATA_W-1:0] max_val;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign idx        = wc[AW-1:0];
  assign in_range   = (wc < WC_LIM) && (wr < WR_LIM);
  assign win_first  = (kc == '0) && (kr == '0);
  assign win_done   = in_range && (kc == K_MAX) && (kr == K_MAX);
  assign frame_last = (wc == WC_LAST) && (wr == WR_LAST);
  assign acc_sel    = acc[idx];

`ifdef MAXPOOL_SIGNED_EN
  assign pix_gt = $signed(in_data) > $signed(acc_sel);
`else
  assign pix_gt = in_data > acc_sel;
`endif

  assign max_val = pix_gt ? in_data : acc_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
      kc  <= '0;
      kr  <= '0;
      wc  <= '0;
      wr  <= '0;
    end else if (accept) begin
      if (col == COL_MAX) begin
        col <= '0;
        kc  <= '0;
        wc  <= '0;
        if (row == ROW_MAX) begin
          row <= '0;
          kr  <= '0;
          wr  <= '0;
        end else begin
          row <= row + 1'b1;
          if (kr == K_MAX) begin
            kr <= '0;
            wr <= wr + 1'b1;
          end else begin
            kr <= kr + 1'b1;
          end
        end
      end else begin
        col <= col + 1'b1;
        if (kc == K_MAX) begin
          kc <= '0;
          wc <= wc + 1'b1;
        end else begin
          kc <= kc + 1'b1;
        end
      end
    end
  end

  // Cropped pixels (wc or wr past the last full window) never touch the bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < OUT_W; i++) acc[i] <= '0;
    end else if (accept && in_range) begin
      acc[idx] <= win_first ? in_data : max_val;
    end
  end

  // A result loading in the same cycle as the handshake keeps out_valid set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept && win_done) begin
        out_valid <= 1'b1;
        out_data  <= max_val;
        out_last  <= frame_last;
      end
    end
  end

endmodule

`default_nettype wire
